// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code set 2 to ASCII decoder with prefix FSM, shift/caps modifiers and output FIFO.
// Optional caps-lock support is built when PS2_DEC_CAPSLOCK_EN is defined.
module ps2_scan_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_ready,
    output logic [7:0] ascii_data,
    output logic       ascii_valid,
    input  logic       ascii_ready,
    output logic       shift_active,
    output logic       overflow
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BRK     = 2'd1;
    localparam logic [1:0] EXT     = 2'd2;
    localparam logic [1:0] EXT_BRK = 2'd3;

    logic [1:0]  state_reg, state_next;
    logic        lshift_reg, lshift_next;
    logic        rshift_reg, rshift_next;
    logic        shift_active_reg;
    logic        overflow_reg;
    logic        caps;
    logic        ignored;
    logic        push_req;
    logic [7:0]  push_char;
    logic [8:0]  lookup;

    logic [7:0]  mem_reg [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic        full, pop, push_ok;

`ifdef PS2_DEC_CAPSLOCK_EN
    logic caps_reg, caps_next, caps_held_reg, caps_held_next;
    assign caps = caps_reg;
`else
    assign caps = 1'b0;
`endif

    // Returns {hit, char}; hit=0 for keys that produce no character.
    function automatic logic [8:0] map_char(input logic [7:0] code, input logic shift_on,
                                            input logic caps_on);
        logic [8:0] r;
        logic [7:0] base;
        base = (shift_on ^ caps_on) ? 8'h41 : 8'h61;
        r    = 9'h000;
        case (code)
            8'h1C: r = {1'b1, base + 8'd0};   8'h32: r = {1'b1, base + 8'd1};
            8'h21: r = {1'b1, base + 8'd2};   8'h23: r = {1'b1, base + 8'd3};
            8'h24: r = {1'b1, base + 8'd4};   8'h2B: r = {1'b1, base + 8'd5};
            8'h34: r = {1'b1, base + 8'd6};   8'h33: r = {1'b1, base + 8'd7};
            8'h43: r = {1'b1, base + 8'd8};   8'h3B: r = {1'b1, base + 8'd9};
            8'h42: r = {1'b1, base + 8'd10};  8'h4B: r = {1'b1, base + 8'd11};
            8'h3A: r = {1'b1, base + 8'd12};  8'h31: r = {1'b1, base + 8'd13};
            8'h44: r = {1'b1, base + 8'd14};  8'h4D: r = {1'b1, base + 8'd15};
            8'h15: r = {1'b1, base + 8'd16};  8'h2D: r = {1'b1, base + 8'd17};
            8'h1B: r = {1'b1, base + 8'd18};  8'h2C: r = {1'b1, base + 8'd19};
            8'h3C: r = {1'b1, base + 8'd20};  8'h2A: r = {1'b1, base + 8'd21};
            8'h1D: r = {1'b1, base + 8'd22};  8'h22: r = {1'b1, base + 8'd23};
            8'h35: r = {1'b1, base + 8'd24};  8'h1A: r = {1'b1, base + 8'd25};
            // Digits ignore caps; shift selects the US-layout symbol row.
            8'h45: r = {1'b1, shift_on ? 8'h29 : 8'h30};
            8'h16: r = {1'b1, shift_on ? 8'h21 : 8'h31};
            8'h1E: r = {1'b1, shift_on ? 8'h40 : 8'h32};
            8'h26: r = {1'b1, shift_on ? 8'h23 : 8'h33};
            8'h25: r = {1'b1, shift_on ? 8'h24 : 8'h34};
            8'h2E: r = {1'b1, shift_on ? 8'h25 : 8'h35};
            8'h36: r = {1'b1, shift_on ? 8'h5E : 8'h36};
            8'h3D: r = {1'b1, shift_on ? 8'h26 : 8'h37};
            8'h3E: r = {1'b1, shift_on ? 8'h2A : 8'h38};
            8'h46: r = {1'b1, shift_on ? 8'h28 : 8'h39};
            8'h29: r = {1'b1, 8'h20};
            8'h5A: r = {1'b1, 8'h0D};
            8'h66: r = {1'b1, 8'h08};
            8'h76: r = {1'b1, 8'h1B};
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    assign ignored = (scan_code == 8'hFA) || (scan_code == 8'hAA) || (scan_code == 8'hFC) ||
                     (scan_code == 8'hFE) || (scan_code == 8'h00) || (scan_code == 8'hFF);
    assign lookup  = map_char(scan_code, lshift_reg | rshift_reg, caps);

    always_comb begin
        state_next  = state_reg;
        lshift_next = lshift_reg;
        rshift_next = rshift_reg;
`ifdef PS2_DEC_CAPSLOCK_EN
        caps_next      = caps_reg;
        caps_held_next = caps_held_reg;
`endif
        push_req  = 1'b0;
        push_char = 8'h00;
        if (scan_ready && !ignored) begin
            if (scan_code == 8'hF0) begin
                state_next = (state_reg == EXT || state_reg == EXT_BRK) ? EXT_BRK : BRK;
            end else if (scan_code == 8'hE0) begin
                state_next = EXT;
            end else begin
                state_next = IDLE;
                case (state_reg)
                    IDLE: begin
                        push_req  = lookup[8];
                        push_char = lookup[7:0];
                        if (scan_code == 8'h12) lshift_next = 1'b1;
                        if (scan_code == 8'h59) rshift_next = 1'b1;
`ifdef PS2_DEC_CAPSLOCK_EN
                        if (scan_code == 8'h58) begin
                            if (!caps_held_reg) caps_next = ~caps_reg;
                            caps_held_next = 1'b1;
                        end
`endif
                    end
                    BRK: begin
                        if (scan_code == 8'h12) lshift_next = 1'b0;
                        if (scan_code == 8'h59) rshift_next = 1'b0;
`ifdef PS2_DEC_CAPSLOCK_EN
                        if (scan_code == 8'h58) caps_held_next = 1'b0;
`endif
                    end
                    EXT: begin
                        // Keypad Enter is the only extended key with a character.
                        push_req  = (scan_code == 8'h5A);
                        push_char = 8'h0D;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ascii_valid = (count_reg != '0);
    assign full        = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign pop         = ascii_valid && ascii_ready;
    assign push_ok     = push_req && (!full || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            lshift_reg       <= 1'b0;
            rshift_reg       <= 1'b0;
            shift_active_reg <= 1'b0;
            overflow_reg     <= 1'b0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_reg[i] <= 8'h00;
        end else begin
            state_reg        <= state_next;
            lshift_reg       <= lshift_next;
            rshift_reg       <= rshift_next;
            shift_active_reg <= lshift_next | rshift_next;
            overflow_reg     <= push_req && full && !pop;
            if (push_ok) begin
                mem_reg[wr_ptr_reg] <= push_char;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifdef PS2_DEC_CAPSLOCK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            caps_reg      <= 1'b0;
            caps_held_reg <= 1'b0;
        end else begin
            caps_reg      <= caps_next;
            caps_held_reg <= caps_held_next;
        end
    end
`endif

    assign ascii_data   = mem_reg[rd_ptr_reg];
    assign shift_active = shift_active_reg;
    assign overflow     = overflow_reg;
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Randomized and directed bench for ps2_scan_decoder against a prefix-flag / queue model.
module tb_ps2_scan_decoder;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] scan_code;
    logic       scan_ready;
    logic [7:0] ascii_data;
    logic       ascii_valid;
    logic       ascii_ready;
    logic       shift_active;
    logic       overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ps2_scan_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .scan_code(scan_code), .scan_ready(scan_ready),
        .ascii_data(ascii_data), .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
        .shift_active(shift_active), .overflow(overflow)
    );

    // Model: pending prefixes as two flags, modifiers as booleans, FIFO as a queue.
    bit         m_ext, m_brk, m_lsh, m_rsh, m_caps, m_caps_held, m_ovf;
    logic [7:0] m_q[$];
    logic [7:0] popped[$];

    logic [7:0] lcodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dcodes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    string      syms  = ")!@#$%^&*(";
    logic [7:0] pool [20] = '{8'h1C, 8'h32, 8'h12, 8'h59, 8'h58, 8'hF0, 8'hE0, 8'h5A, 8'h16, 8'h45,
                              8'h29, 8'h66, 8'h76, 8'hFA, 8'hAA, 8'h00, 8'hFF, 8'h75, 8'h3E, 8'hF0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [7:0] code, input bit shift_on, input bit caps_on);
        for (int i = 0; i < 26; i++)
            if (code == lcodes[i]) return ((shift_on ^ caps_on) ? 32'h41 : 32'h61) + i;
        for (int i = 0; i < 10; i++)
            if (code == dcodes[i]) return shift_on ? int'(syms[i]) : 32'h30 + i;
        case (code)
            8'h29:   return 32'h20;
            8'h5A:   return 32'h0D;
            8'h66:   return 32'h08;
            8'h76:   return 32'h1B;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_lsh = 0; m_rsh = 0; m_caps = 0; m_caps_held = 0; m_ovf = 0;
        m_q.delete();
    endtask

    // One clock cycle: drive, check pop data, advance model, check outputs after the edge.
    task automatic step(input logic [7:0] code, input bit strobe, input bit ready);
        bit pop;
        int ch;
        @(negedge clk);
        scan_code = code; scan_ready = strobe; ascii_ready = ready;
        #1;
        pop = (m_q.size() > 0) && ready;
        ch  = -1;
        if (pop) begin
            check("pop_data", {24'h0, ascii_data}, {24'h0, m_q[0]});
            popped.push_back(ascii_data);
            $display("[TB] pop char 0x%02h", ascii_data);
            void'(m_q.pop_front());
        end
        m_ovf = 0;
        if (strobe && !(code inside {8'hFA, 8'hAA, 8'hFC, 8'hFE, 8'h00, 8'hFF})) begin
            if (code == 8'hF0) m_brk = 1;
            else if (code == 8'hE0) begin m_ext = 1; m_brk = 0; end
            else begin
                if (!m_ext && !m_brk) begin
                    ch = lookup(code, m_lsh | m_rsh, m_caps);
                    if (code == 8'h12) m_lsh = 1;
                    if (code == 8'h59) m_rsh = 1;
`ifdef PS2_DEC_CAPSLOCK_EN
                    if (code == 8'h58) begin
                        if (!m_caps_held) m_caps = !m_caps;
                        m_caps_held = 1;
                    end
`endif
                end else if (!m_ext && m_brk) begin
                    if (code == 8'h12) m_lsh = 0;
                    if (code == 8'h59) m_rsh = 0;
                    if (code == 8'h58) m_caps_held = 0;
                end else if (m_ext && !m_brk) begin
                    if (code == 8'h5A) ch = 32'h0D;
                end
                m_ext = 0; m_brk = 0;
            end
        end
        if (ch >= 0) begin
            if (m_q.size() < DEPTH) m_q.push_back(8'(ch));
            else m_ovf = 1;
        end
        @(posedge clk);
        #1;
        check("valid", {31'h0, ascii_valid}, {31'h0, m_q.size() > 0});
        if (m_q.size() > 0) check("data", {24'h0, ascii_data}, {24'h0, m_q[0]});
        check("shift", {31'h0, shift_active}, {31'h0, m_lsh | m_rsh});
        check("overflow", {31'h0, overflow}, {31'h0, m_ovf});
    endtask

    task automatic send(input logic [7:0] code);
        step(code, 1'b1, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && m_q.size() > 0; i++) step(8'h00, 1'b0, 1'b1);
        check("drained", {31'h0, ascii_valid}, 32'h0);
    endtask

    task automatic expect_chars(input string tag, input string exp);
        check({tag, "_count"}, popped.size(), exp.len());
        for (int i = 0; i < exp.len() && i < popped.size(); i++)
            check(tag, {24'h0, popped[i]}, {24'h0, exp[i]});
        popped.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        scan_ready = 1'b0; ascii_ready = 1'b0; reset = 1'b0;
        #2;
        model_reset();
        check("rst_valid", {31'h0, ascii_valid}, 32'h0);
        check("rst_data", {24'h0, ascii_data}, 32'h0);
        check("rst_shift", {31'h0, shift_active}, 32'h0);
        check("rst_ovf", {31'h0, overflow}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; scan_code = 8'h00; scan_ready = 1'b0; ascii_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Make then break of 'a'
        send(8'h1C); send(8'hF0); send(8'h1C);
        drain();
        expect_chars("make_break", "a");

        // Shift handling
        send(8'h12);
        check("shift_on", {31'h0, shift_active}, 32'h1);
        send(8'h1C); send(8'h16); send(8'hF0); send(8'h12);
        check("shift_off", {31'h0, shift_active}, 32'h0);
        send(8'h1C);
        drain();
        expect_chars("shift", "A!a");

        // Extended and ignored codes; trailing 'a' proves FSM returned to IDLE
        send(8'hE0); send(8'h5A); send(8'hE0); send(8'hF0); send(8'h5A);
        send(8'hFA); send(8'hAA); send(8'hE0); send(8'h75); send(8'h1C);
        drain();
        check("ext_count", popped.size(), 2);
        if (popped.size() == 2) begin
            check("ext_enter", {24'h0, popped[0]}, 32'h0D);
            check("ext_idle", {24'h0, popped[1]}, 32'h61);
        end
        popped.delete();

        // Fill and overflow, then drain on consecutive cycles
        send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        send(8'h2E);
        check("ovf_pulse", {31'h0, overflow}, 32'h1);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b1);
        check("ovf_empty", {31'h0, ascii_valid}, 32'h0);
        expect_chars("overflow", "1234");

        // Full FIFO with simultaneous push and pop
        send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        step(8'h2E, 1'b1, 1'b1);
        check("full_pushpop_ovf", {31'h0, overflow}, 32'h0);
        drain();
        expect_chars("full_pushpop", "12345");

`ifdef PS2_DEC_CAPSLOCK_EN
        send(8'h58); send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h12);
        drain();
        expect_chars("caps", "Aa");
        send(8'h58); send(8'hF0); send(8'h58);
`endif

        // Reset in the middle of a break sequence, with a queued char
        send(8'h1C); send(8'hF0);
        do_reset();
        send(8'h1C);
        drain();
        expect_chars("mid_reset", "a");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 19)];
            step(b, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
            if (n % 1000 == 999) begin
                do_reset();
                popped.delete();
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
